// File: rtl/nfc_rx_deframer.sv
// nfc_rx_deframer: recovers start/8-data/stop framed bytes from the demodulated nfc receive stream.
// Synchronised, majority-filtered input feeds a mid-bit sampling FSM with a valid/ready byte output.
module nfc_rx_deframer #(
    parameter int BIT_CYCLES = 100,
    parameter int CNT_W      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, RECOVER} state_t;

    localparam logic [CNT_W-1:0] HALF = CNT_W'(BIT_CYCLES / 2 - 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_CYCLES - 1);

    state_t           state, state_n;
    logic [1:0]       sync;
    logic [2:0]       hist;
    logic             rx_f, rx_fd;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, idx_n;
    logic [7:0]       shift_reg, sh_n;
    logic             deliver, bad;

    assign rx_f = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
    assign busy = state != IDLE;

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        idx_n   = bit_idx;
        sh_n    = shift_reg;
        deliver = 1'b0;
        bad     = 1'b0;
        case (state)
            IDLE: begin
                cnt_n   = '0;
                state_n = (rx_f & ~rx_fd) ? START : IDLE;
            end
            START: if (cnt == HALF) begin
                cnt_n   = '0;
                idx_n   = 3'd0;
                state_n = rx_f ? DATA : IDLE;
            end
            DATA: if (cnt == LAST) begin
                cnt_n          = '0;
                sh_n[bit_idx]  = rx_f;
                idx_n          = bit_idx + 3'd1;
                state_n        = (bit_idx == 3'd7) ? STOP : DATA;
            end
            STOP: if (cnt == LAST) begin
                cnt_n   = '0;
                deliver = ~rx_f;
                bad     = rx_f;
                state_n = rx_f ? RECOVER : IDLE;
            end
            RECOVER: begin
                cnt_n   = '0;
                state_n = rx_f ? RECOVER : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync       <= '0;
            hist       <= '0;
            rx_fd      <= 1'b0;
            cnt        <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            sync      <= {sync[0], rx_in};
            hist      <= {hist[1:0], sync[1]};
            rx_fd     <= rx_f;
            cnt       <= cnt_n;
            bit_idx   <= idx_n;
            shift_reg <= sh_n;
            frame_err <= bad;
            if (deliver && (!data_valid || data_ready)) begin
                data_out   <= sh_n;
                data_valid <= 1'b1;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
            // a completed byte that cannot be held is dropped and remembered
            if (deliver && data_valid && !data_ready) overrun <= 1'b1;
        end
    end
endmodule

// File: doc/nfc_rx_deframer.md
Name: nfc_rx_deframer

Overview:
- Recovers bytes from the demodulated digital receive stream (rx_recv of the nfc link model) and presents them on a valid/ready byte interface.
- Sits directly downstream of the nfc block and runs on the emulation clock.
- Synchronises and glitch-filters the input, detects start bits, samples each bit at mid-bit, checks the stop bit, and flags framing errors and output overruns.
- Frame format: idle level 0, start bit 1, 8 data bits LSB first, stop bit 0, each bit BIT_CYCLES clocks long.

Parameters:
- BIT_CYCLES, 100, clock cycles per bit (e.g. 10 MHz clk / 100 kb/s); legal range 4..65535.
- CNT_W, 16, bit-counter width; must satisfy 2^CNT_W > BIT_CYCLES.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- rx_in  input  1  demodulated receive bit stream (connects to rx_recv); asynchronous to clk.
- data_out  output  8  received byte; stable while data_valid=1.
- data_valid  output  1  byte available; held until accepted.
- data_ready  input  1  consumer accepts data_out when data_valid & data_ready.
- frame_err  output  1  one-cycle pulse on bad stop bit.
- overrun  output  1  sticky; a byte was dropped because the holding register was full.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; synchroniser and filter flops=0; counters=0; data_out=0, data_valid=0, frame_err=0, overrun=0, busy=0. Reset mid-frame aborts the frame; the partial byte is never delivered.
- Input path: 2-flop synchroniser, then a 3-sample majority filter over the last three synchronised samples, giving rx_f. A single-cycle glitch never changes rx_f. Latency from a stable rx_in change to rx_f is 4 clk cycles.
- FSM states: IDLE, START, DATA, STOP, RECOVER.
- IDLE: rx_f rising edge (previous 0, current 1) -> START, with cnt=0.
- START: cnt increments each cycle. At cnt==BIT_CYCLES/2-1 (integer floor), sample rx_f:
  - 0 -> IDLE (false start, no flag).
  - 1 -> DATA, with cnt=0 and bit_idx=0.
- DATA: cnt counts 0..BIT_CYCLES-1. At terminal count:
  - shift rx_f into shift_reg[bit_idx] (LSB first), cnt=0, bit_idx++.
  - after bit_idx 7 -> STOP.
  - Sampling points are therefore mid-bit.
- STOP: at cnt==BIT_CYCLES-1, sample rx_f:
  - 0 -> deliver byte, go to IDLE.
  - 1 -> frame_err=1 for exactly one cycle, byte discarded, go to RECOVER.
- RECOVER: wait for rx_f==0, then IDLE. This prevents a false start inside a stuck-high line.
- Delivery at the STOP decision cycle:
  - If data_valid=0, or data_valid&data_ready in the same cycle: load data_out, data_valid=1 on the next cycle.
  - Otherwise: keep the old byte and set overrun=1 (sticky until rst).
- Handshake: when data_valid&data_ready with no simultaneous delivery, data_valid clears on the next cycle. data_out changes only on load.
- busy = (state != IDLE). busy rises the cycle after the rx_f rising edge.
- Back-to-back frames: a start bit immediately after the stop bit is detected because STOP returns to IDLE with rx_f=0. No idle gap is required beyond the stop bit.
- Counter widths: cnt is CNT_W bits and never wraps in legal configurations; bit_idx is 3 bits.

Test Plan:
- Send 0xA5 with BIT_CYCLES=8 (start 1, bits 1,0,1,0,0,1,0,1, stop 0) -> data_valid rises, data_out=0xA5, frame_err=0, overrun=0; data_valid holds until data_ready=1, then drops the next cycle.
- One-cycle rx_in pulse, then a two-cycle pulse, while idle -> busy never asserts / START aborts to IDLE; no data_valid, no frame_err.
- Frame 0x3C with stop bit driven 1 and the line held high 20 cycles -> frame_err one-cycle pulse, no data_valid, busy stays high until rx_in returns to 0, then IDLE.
- Two frames 0x11 then 0x22 back-to-back with data_ready=0 -> data_out=0x11 retained, overrun=1 after the second stop; with data_ready=1 throughout -> both bytes delivered in order, overrun=0.
- rst pulse during data bit 4 of 0xFF, line returned low -> all outputs 0, no byte delivered; a subsequent 0x5A frame is received correctly.
- BIT_CYCLES=5 (odd), send 0x81 -> START samples at cnt=1; data_out=0x81.
